// File: rtl/traffic_phase_ctrl.sv
// Traffic light phase controller: RED -> GREEN -> YELLOW timed by a synchronised 1 Hz input,
// with a latched pedestrian request that cuts the remaining green time short.
module traffic_phase_ctrl #(
    parameter int GREEN_SEC     = 30,
    parameter int YELLOW_SEC    = 3,
    parameter int RED_SEC       = 20,
    parameter int MIN_GREEN_SEC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       ped_req,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic       walk,
    output logic [5:0] sec_left,
    output logic       ped_pending,
    output logic       sec_tick
);

    localparam logic [1:0] ST_RED    = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;

    localparam logic [5:0] L_GREEN  = 6'(GREEN_SEC);
    localparam logic [5:0] L_YELLOW = 6'(YELLOW_SEC);
    localparam logic [5:0] L_RED    = 6'(RED_SEC);
    localparam logic [5:0] L_MIN    = 6'(MIN_GREEN_SEC);

    logic       r_s1, r_s2, r_s3;
    logic [1:0] r_state;
    logic [5:0] r_sec_left;
    logic       r_ped;
    logic       r_red, r_yellow, r_green;

    logic       w_tick;
    logic       w_enter_red;
    logic [1:0] w_next_state;
    logic [5:0] w_next_left;

    // Edge detect works only on synchronised copies; sec_in never reaches logic directly.
    assign w_tick = r_s2 & ~r_s3;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_next_state = r_state;
        w_next_left  = r_sec_left;
        if (w_tick) begin
            if (r_sec_left == 6'd1) begin
                case (r_state)
                    ST_RED: begin
                        w_next_state = ST_GREEN;
                        w_next_left  = L_GREEN;
                    end
                    ST_GREEN: begin
                        w_next_state = ST_YELLOW;
                        w_next_left  = L_YELLOW;
                    end
                    default: begin
                        w_next_state = ST_RED;
                        w_next_left  = L_RED;
                    end
                endcase
            end else if (r_state == ST_GREEN && r_ped && r_sec_left > L_MIN) begin
                w_next_left = L_MIN;
            end else begin
                w_next_left = r_sec_left - 6'd1;
            end
        end
    end

    assign w_enter_red = (w_next_state == ST_RED) && (r_state != ST_RED);

    // Lamps decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_s3       <= 1'b1;
            r_state    <= ST_RED;
            r_sec_left <= L_RED;
            r_ped      <= 1'b0;
            r_red      <= 1'b1;
            r_yellow   <= 1'b0;
            r_green    <= 1'b0;
        end else begin
            r_s1       <= sec_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_state    <= w_next_state;
            r_sec_left <= w_next_left;
            if (w_enter_red)
                r_ped <= 1'b0;
            else if (ped_req && r_state != ST_RED)
                r_ped <= 1'b1;
            r_red      <= (w_next_state == ST_RED);
            r_yellow   <= (w_next_state == ST_YELLOW);
            r_green    <= (w_next_state == ST_GREEN);
        end
    end

    assign red         = r_red;
    assign yellow      = r_yellow;
    assign green       = r_green;
    assign walk        = r_red;
    assign sec_left    = r_sec_left;
    assign ped_pending = r_ped;
    assign sec_tick    = w_tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed phase walk-through followed by
// randomized pedestrian/second-pulse traffic checked against a phase-table reference model.
module tb_traffic_phase_ctrl;

    localparam int G_SEC   = 4;
    localparam int Y_SEC   = 2;
    localparam int R_SEC   = 3;
    localparam int MIN_SEC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_in;
    logic       ped_req;
    logic       red, yellow, green, walk;
    logic [5:0] sec_left;
    logic       ped_pending;
    logic       sec_tick;

    traffic_phase_ctrl #(
        .GREEN_SEC    (G_SEC),
        .YELLOW_SEC   (Y_SEC),
        .RED_SEC      (R_SEC),
        .MIN_GREEN_SEC(MIN_SEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_in     (sec_in),
        .ped_req    (ped_req),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .walk       (walk),
        .sec_left   (sec_left),
        .ped_pending(ped_pending),
        .sec_tick   (sec_tick)
    );

    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase index 0=RED, 1=GREEN, 2=YELLOW, durations looked up by index.
    int dur[3] = '{R_SEC, G_SEC, Y_SEC};
    int m_phase;
    int m_left;
    bit m_ped;

    function automatic logic [2:0] lamps_of(input int phase);
        case (phase)
            0:       return 3'b100;
            1:       return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_left  = R_SEC;
        m_ped   = 1'b0;
    endtask

    task automatic model_edge(input bit tick, input bit ped);
        int old_phase = m_phase;
        bit old_ped   = m_ped;
        bit enter_red = 1'b0;
        if (tick) begin
            if (m_left == 1) begin
                m_phase   = (m_phase + 1) % 3;
                m_left    = dur[m_phase];
                enter_red = (m_phase == 0);
            end else if (m_phase == 1 && old_ped && m_left > MIN_SEC) begin
                m_left = MIN_SEC;
            end else begin
                m_left = m_left - 1;
            end
        end
        m_ped = enter_red ? 1'b0 : (old_ped | (ped && old_phase != 0));
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".sec_left"}, sec_left, m_left);
        cmp({tag, ".lamps"}, {red, yellow, green}, lamps_of(m_phase));
        cmp({tag, ".walk"}, walk, (m_phase == 0));
        cmp({tag, ".ped_pending"}, ped_pending, m_ped);
    endtask

    // All tasks below start and end just after a falling clock edge.
    task automatic ped_pulse();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        model_edge(1'b0, 1'b1);
        check_all("ped_pulse");
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        check_all("idle");
    endtask

    task automatic sec_edge(input bit ped_at_tick, input int hold);
        sec_in = 1'b1;
        @(negedge clk);
        cmp("tick_after_1st_edge", sec_tick, 1'b0);
        @(negedge clk);
        cmp("tick_after_2nd_edge", sec_tick, 1'b1);
        check_all("before_update");
        ped_req = ped_at_tick;
        @(negedge clk);
        ped_req = 1'b0;
        model_edge(1'b1, ped_at_tick);
        check_all("after_tick");
        cmp("tick_after_3rd_edge", sec_tick, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmp("tick_while_held_high", sec_tick, 1'b0);
        end
        sec_in = 1'b0;
        repeat ($urandom_range(3, 6)) @(negedge clk);
        check_all("after_low");
    endtask

    int exp_left[9]  = '{2, 1, 4, 3, 2, 1, 2, 1, 3};
    int exp_phase[9] = '{0, 0, 1, 1, 1, 1, 2, 2, 0};

    initial begin
        rst     = 1'b1;
        sec_in  = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("reset");
        cmp("reset_tick", sec_tick, 1'b0);
        idle(3);

        // Full cycle R3..R3; the first edge is also held high 50 cycles.
        for (int i = 0; i < 9; i++) begin
            sec_edge(1'b0, (i == 0) ? 50 : 0);
            cmp("seq_left", sec_left, exp_left[i]);
            cmp("seq_lamps", {red, yellow, green}, lamps_of(exp_phase[i]));
        end

        // Pedestrian during RED is ignored.
        ped_pulse();
        cmp("ped_in_red", ped_pending, 1'b0);

        // Pedestrian at G4 shortens green to MIN, then clears on RED entry.
        repeat (3) sec_edge(1'b0, 0);
        cmp("at_g4", sec_left, 4);
        ped_pulse();
        cmp("ped_set_g4", ped_pending, 1'b1);
        sec_edge(1'b0, 0);
        cmp("g4_short_to_g2", sec_left, 2);
        cmp("g4_short_green", green, 1'b1);
        repeat (4) sec_edge(1'b0, 0);
        cmp("r3_after_ped", sec_left, 3);
        cmp("ped_clear_on_red", ped_pending, 1'b0);
        cmp("walk_on_red", walk, 1'b1);

        // Pedestrian at G2: already at or below MIN, plain decrement.
        repeat (5) sec_edge(1'b0, 0);
        ped_pulse();
        sec_edge(1'b0, 0);
        cmp("g2_no_load", sec_left, 1);
        cmp("g2_still_green", green, 1'b1);

        // Request on the very edge that enters RED: clear wins.
        repeat (2) sec_edge(1'b0, 0);
        cmp("ped_kept_in_yellow", ped_pending, 1'b1);
        sec_edge(1'b1, 0);
        cmp("ped_clear_dominates", ped_pending, 1'b0);
        cmp("red_after_clear", red, 1'b1);

        // Reset at Y1 mid-synchroniser with sec_in held high.
        repeat (8) sec_edge(1'b0, 0);
        cmp("at_y1", {yellow, sec_left}, {1'b1, 6'd1});
        sec_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("reset_at_y1");
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cmp("no_tick_after_reset", sec_tick, 1'b0);
        end
        check_all("held_after_reset");
        sec_in = 1'b0;
        repeat (3) @(negedge clk);
        sec_edge(1'b0, 0);
        cmp("fresh_edge_after_reset", sec_left, 2);

        // Randomized traffic.
        repeat (60) begin
            if ($urandom_range(0, 3) == 0) ped_pulse();
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                check_all("rand_reset");
                idle(3);
            end
            sec_edge($urandom_range(0, 4) == 0, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
